// File: rtl/dispatch_queue.sv
// Dispatch queue: buffers decoded instructions, resolves operands and
// issues one per cycle into the ROB and the selected RS or LSB.
module dispatch_queue #(
    parameter int DEPTH    = 8,
    parameter int NUM_CDB  = 2,
    parameter int ROB_ID_W = 4,
    parameter int XLEN     = 32,
    parameter int OP_W     = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         rollback,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [XLEN-1:0]              in_pc,
    input  logic [XLEN-1:0]              in_imm,
    input  logic [OP_W-1:0]              in_optype,
    input  logic [4:0]                   in_rd,
    input  logic [4:0]                   in_rs1,
    input  logic [4:0]                   in_rs2,
    input  logic                         in_is_ls,
    input  logic                         in_is_jump,
    input  logic                         in_pred_jump,
    input  logic                         rob_full,
    input  logic                         rs_full,
    input  logic                         lsb_full,
    input  logic [ROB_ID_W-1:0]          rob_id,
    output logic [4:0]                   rs1_idx,
    output logic [4:0]                   rs2_idx,
    input  logic [ROB_ID_W-1:0]          rf_q1,
    input  logic [ROB_ID_W-1:0]          rf_q2,
    input  logic [XLEN-1:0]              rf_v1,
    input  logic [XLEN-1:0]              rf_v2,
    input  logic                         rob_q1_rdy,
    input  logic                         rob_q2_rdy,
    input  logic [XLEN-1:0]              rob_v1,
    input  logic [XLEN-1:0]              rob_v2,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*ROB_ID_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]      cdb_data,
    output logic                         rob_we,
    output logic [XLEN-1:0]              rob_pc,
    output logic [4:0]                   rob_rd,
    output logic [OP_W-1:0]              rob_optype,
    output logic                         rob_is_jump,
    output logic                         rob_pred_jump,
    output logic                         ren_we,
    output logic [4:0]                   ren_rd,
    output logic [ROB_ID_W-1:0]          ren_tag,
    output logic                         rs_we,
    output logic                         lsb_we,
    output logic [ROB_ID_W-1:0]          iss_tag,
    output logic [OP_W-1:0]              iss_optype,
    output logic [XLEN-1:0]              iss_pc,
    output logic [XLEN-1:0]              iss_imm,
    output logic [ROB_ID_W-1:0]          iss_q1,
    output logic [ROB_ID_W-1:0]          iss_q2,
    output logic [XLEN-1:0]              iss_v1,
    output logic [XLEN-1:0]              iss_v2,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [OP_W-1:0] optype;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            is_ls;
        logic            is_jump;
        logic            pred_jump;
    } ent_t;

    typedef struct packed {
        logic [ROB_ID_W-1:0] q;
        logic [XLEN-1:0]     v;
    } opnd_t;

    // The ren_* fields double as the pending-rename register.
    typedef struct packed {
        logic                rob_we;
        logic                rs_we;
        logic                lsb_we;
        logic                ren_we;
        logic [ROB_ID_W-1:0] tag;
        logic [4:0]          rd;
        logic [OP_W-1:0]     optype;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     imm;
        logic                is_jump;
        logic                pred_jump;
        opnd_t               op1;
        opnd_t               op2;
    } out_t;

    function automatic opnd_t resolve(
        input logic [4:0]                  idx,
        input logic                        pend_we,
        input logic [4:0]                  pend_rd,
        input logic [ROB_ID_W-1:0]         pend_tag,
        input logic                        rob_rdy,
        input logic [XLEN-1:0]             rob_v,
        input logic [ROB_ID_W-1:0]         rf_q,
        input logic [XLEN-1:0]             rf_v,
        input logic [NUM_CDB-1:0]          cv,
        input logic [NUM_CDB*ROB_ID_W-1:0] ct,
        input logic [NUM_CDB*XLEN-1:0]     cd
    );
        opnd_t r;
        logic  hit;
        r   = '0;
        hit = 1'b0;
        if (idx == 5'd0) begin
            r = '0;
        end else if (pend_we && pend_rd == idx) begin
            r.q = pend_tag;
        end else if (rob_rdy) begin
            r.v = rob_v;
        end else begin
            r.q = rf_q;
            r.v = rf_v;
        end
        if (r.q != '0) begin
            for (int k = 0; k < NUM_CDB; k++) begin
                if (!hit && cv[k] &&
                    ct[k*ROB_ID_W +: ROB_ID_W] == r.q) begin
                    hit = 1'b1;
                    r.v = cd[k*XLEN +: XLEN];
                end
            end
        end
        if (hit) r.q = '0;
        return r;
    endfunction

    ent_t             mem_q [DEPTH];
    ent_t             in_ent;
    ent_t             head;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    out_t             out_q, out_d;
    logic             enq;
    logic             issue;
    opnd_t            op1, op2;

    assign in_ent = '{pc: in_pc, imm: in_imm, optype: in_optype,
                      rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                      is_ls: in_is_ls, is_jump: in_is_jump,
                      pred_jump: in_pred_jump};

    assign head     = mem_q[head_q];
    assign in_ready = (count_q < CNT_W'(DEPTH)) && !rollback;
    assign enq      = in_valid && in_ready && rdy;
    assign issue    = rdy && !rollback && (count_q != '0) && !rob_full &&
                      !(head.is_ls ? lsb_full : rs_full);

    // Queue storage written at the tail on every accepted enqueue.
    always_ff @(posedge clk) begin
        if (enq) mem_q[tail_q] <= in_ent;
    end

    // Resolve both head operands against pending rename, ROB, RF and CDB.
    always_comb begin
        op1 = resolve(head.rs1, out_q.ren_we, out_q.rd, out_q.tag,
                      rob_q1_rdy, rob_v1, rf_q1, rf_v1,
                      cdb_valid, cdb_tag, cdb_data);
        op2 = resolve(head.rs2, out_q.ren_we, out_q.rd, out_q.tag,
                      rob_q2_rdy, rob_v2, rf_q2, rf_v2,
                      cdb_valid, cdb_tag, cdb_data);
    end

    // Pointer, occupancy and issue-register next state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        out_d   = out_q;
        if (rollback) begin
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            out_d.rob_we  = 1'b0;
            out_d.rs_we   = 1'b0;
            out_d.lsb_we  = 1'b0;
            out_d.ren_we  = 1'b0;
        end else if (rdy) begin
            if (enq)   tail_d = tail_q + 1'b1;
            if (issue) head_d = head_q + 1'b1;
            count_d = count_q + CNT_W'(enq) - CNT_W'(issue);
            out_d.rob_we = issue;
            out_d.rs_we  = issue && !head.is_ls;
            out_d.lsb_we = issue && head.is_ls;
            out_d.ren_we = issue && (head.rd != 5'd0);
            if (issue) begin
                out_d.tag       = rob_id;
                out_d.rd        = head.rd;
                out_d.optype    = head.optype;
                out_d.pc        = head.pc;
                out_d.imm       = head.imm;
                out_d.is_jump   = head.is_jump;
                out_d.pred_jump = head.pred_jump;
                out_d.op1       = op1;
                out_d.op2       = op2;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            out_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            out_q   <= out_d;
        end
    end

    assign rs1_idx       = head.rs1;
    assign rs2_idx       = head.rs2;
    assign count         = count_q;
    assign rob_we        = out_q.rob_we;
    assign rob_pc        = out_q.pc;
    assign rob_rd        = out_q.rd;
    assign rob_optype    = out_q.optype;
    assign rob_is_jump   = out_q.is_jump;
    assign rob_pred_jump = out_q.pred_jump;
    assign ren_we        = out_q.ren_we;
    assign ren_rd        = out_q.rd;
    assign ren_tag       = out_q.tag;
    assign rs_we         = out_q.rs_we;
    assign lsb_we        = out_q.lsb_we;
    assign iss_tag       = out_q.tag;
    assign iss_optype    = out_q.optype;
    assign iss_pc        = out_q.pc;
    assign iss_imm       = out_q.imm;
    assign iss_q1        = out_q.op1.q;
    assign iss_q2        = out_q.op2.q;
    assign iss_v1        = out_q.op1.v;
    assign iss_v2        = out_q.op2.v;

endmodule

// File: tb/tb_dispatch_queue.sv
// Randomised bench for dispatch_queue against a queue-based model
// of the dispatch rules, plus a few directed scenarios.
module tb_dispatch_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, in_valid, in_ready;
    logic [31:0] in_pc, in_imm;
    logic [5:0]  in_optype;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic        in_is_ls, in_is_jump, in_pred_jump;
    logic        rob_full, rs_full, lsb_full;
    logic [3:0]  rob_id;
    logic [4:0]  rs1_idx, rs2_idx;
    logic [3:0]  rf_q1, rf_q2;
    logic [31:0] rf_v1, rf_v2;
    logic        rob_q1_rdy, rob_q2_rdy;
    logic [31:0] rob_v1, rob_v2;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_data;
    logic        rob_we, rob_is_jump, rob_pred_jump, ren_we, rs_we, lsb_we;
    logic [31:0] rob_pc, iss_pc, iss_imm, iss_v1, iss_v2;
    logic [4:0]  rob_rd, ren_rd;
    logic [5:0]  rob_optype, iss_optype;
    logic [3:0]  ren_tag, iss_tag, iss_q1, iss_q2;
    logic [3:0]  count;

    dispatch_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .in_optype(in_optype),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_is_ls(in_is_ls), .in_is_jump(in_is_jump),
        .in_pred_jump(in_pred_jump),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .rob_id(rob_id), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rf_q1(rf_q1), .rf_q2(rf_q2), .rf_v1(rf_v1), .rf_v2(rf_v2),
        .rob_q1_rdy(rob_q1_rdy), .rob_q2_rdy(rob_q2_rdy),
        .rob_v1(rob_v1), .rob_v2(rob_v2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .rob_we(rob_we), .rob_pc(rob_pc), .rob_rd(rob_rd),
        .rob_optype(rob_optype), .rob_is_jump(rob_is_jump),
        .rob_pred_jump(rob_pred_jump),
        .ren_we(ren_we), .ren_rd(ren_rd), .ren_tag(ren_tag),
        .rs_we(rs_we), .lsb_we(lsb_we),
        .iss_tag(iss_tag), .iss_optype(iss_optype),
        .iss_pc(iss_pc), .iss_imm(iss_imm),
        .iss_q1(iss_q1), .iss_q2(iss_q2),
        .iss_v1(iss_v1), .iss_v2(iss_v2),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, imm;
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic        ls, jmp, pj;
    } ins_t;

    ins_t        mq[$];
    logic        e_rob, e_rs, e_lsb, e_ren, e_jmp, e_pj;
    logic [3:0]  e_tag, e_q1, e_q2;
    logic [4:0]  e_rd;
    logic [5:0]  e_op;
    logic [31:0] e_pc, e_imm, e_v1, e_v2;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        {e_rob, e_rs, e_lsb, e_ren, e_jmp, e_pj} = '0;
        {e_tag, e_q1, e_q2, e_rd, e_op} = '0;
        {e_pc, e_imm, e_v1, e_v2} = '0;
    endtask

    // Operand lookup following the priority list for one source.
    task automatic lookup(input logic [4:0] idx, input logic [3:0] rq,
                          input logic [31:0] rv, input logic rr,
                          input logic [31:0] robv,
                          output logic [3:0] q, output logic [31:0] v);
        q = 0;
        v = 0;
        if (idx != 0) begin
            if (e_ren && e_rd == idx) q = e_tag;
            else if (rr) v = robv;
            else begin q = rq; v = rv; end
            if (q != 0) begin
                if (cdb_valid[0] && cdb_tag[3:0] == q) begin
                    q = 0; v = cdb_data[31:0];
                end else if (cdb_valid[1] && cdb_tag[7:4] == q) begin
                    q = 0; v = cdb_data[63:32];
                end
            end
        end
    endtask

    task automatic model_step();
        bit   iss, enq;
        ins_t h, n;
        logic [3:0]  q1, q2;
        logic [31:0] v1, v2;
        if (rollback) begin
            mq.delete();
            {e_rob, e_rs, e_lsb, e_ren} = '0;
        end else if (rdy) begin
            iss = mq.size() > 0 && !rob_full &&
                  !(mq[0].ls ? lsb_full : rs_full);
            enq = in_valid && mq.size() < DEPTH;
            if (iss) begin
                h = mq.pop_front();
                lookup(h.rs1, rf_q1, rf_v1, rob_q1_rdy, rob_v1, q1, v1);
                lookup(h.rs2, rf_q2, rf_v2, rob_q2_rdy, rob_v2, q2, v2);
                e_rob = 1; e_rs = !h.ls; e_lsb = h.ls;
                e_ren = h.rd != 0;
                e_tag = rob_id; e_rd = h.rd; e_op = h.op;
                e_pc = h.pc; e_imm = h.imm; e_jmp = h.jmp; e_pj = h.pj;
                e_q1 = q1; e_q2 = q2; e_v1 = v1; e_v2 = v2;
            end else begin
                {e_rob, e_rs, e_lsb, e_ren} = '0;
            end
            if (enq) begin
                n.pc = in_pc; n.imm = in_imm; n.op = in_optype;
                n.rd = in_rd; n.rs1 = in_rs1; n.rs2 = in_rs2;
                n.ls = in_is_ls; n.jmp = in_is_jump; n.pj = in_pred_jump;
                mq.push_back(n);
            end
        end
    endtask

    task automatic check_regs();
        chk("count", count, mq.size());
        chk("rob_we", rob_we, e_rob);
        chk("rs_we", rs_we, e_rs);
        chk("lsb_we", lsb_we, e_lsb);
        chk("ren_we", ren_we, e_ren);
        chk("ren_rd", ren_rd, e_rd);
        chk("ren_tag", ren_tag, e_tag);
        chk("rob_rd", rob_rd, e_rd);
        chk("rob_pc", rob_pc, e_pc);
        chk("rob_optype", rob_optype, e_op);
        chk("rob_is_jump", rob_is_jump, e_jmp);
        chk("rob_pred_jump", rob_pred_jump, e_pj);
        chk("iss_tag", iss_tag, e_tag);
        chk("iss_optype", iss_optype, e_op);
        chk("iss_pc", iss_pc, e_pc);
        chk("iss_imm", iss_imm, e_imm);
        chk("iss_q1", iss_q1, e_q1);
        chk("iss_q2", iss_q2, e_q2);
        chk("iss_v1", iss_v1, e_v1);
        chk("iss_v2", iss_v2, e_v2);
    endtask

    // Inputs are driven at the falling edge before calling this.
    task automatic tick();
        #1;
        chk("in_ready", in_ready, mq.size() < DEPTH && !rollback);
        if (mq.size() > 0) begin
            chk("rs1_idx", rs1_idx, mq[0].rs1);
            chk("rs2_idx", rs2_idx, mq[0].rs2);
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_regs();
    endtask

    task automatic idle_inputs();
        rdy = 1; rollback = 0; in_valid = 0;
        in_pc = 0; in_imm = 0; in_optype = 0;
        in_rd = 0; in_rs1 = 0; in_rs2 = 0;
        in_is_ls = 0; in_is_jump = 0; in_pred_jump = 0;
        rob_full = 0; rs_full = 0; lsb_full = 0; rob_id = 0;
        rf_q1 = 0; rf_q2 = 0; rf_v1 = 0; rf_v2 = 0;
        rob_q1_rdy = 0; rob_q2_rdy = 0; rob_v1 = 0; rob_v2 = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    endtask

    task automatic rand_instr();
        in_pc = $urandom; in_imm = $urandom;
        in_optype = 6'($urandom);
        in_rd = 5'($urandom_range(0, 7));
        in_rs1 = 5'($urandom_range(0, 7));
        in_rs2 = 5'($urandom_range(0, 7));
        in_is_ls = 1'($urandom_range(0, 2) == 0);
        in_is_jump = 1'($urandom);
        in_pred_jump = 1'($urandom);
    endtask

    task automatic rand_inputs();
        rand_instr();
        rdy = $urandom_range(0, 99) < 85;
        rollback = $urandom_range(0, 99) < 3;
        in_valid = $urandom_range(0, 99) < 70;
        rob_full = $urandom_range(0, 99) < 15;
        rs_full = $urandom_range(0, 99) < 25;
        lsb_full = $urandom_range(0, 99) < 25;
        rob_id = 4'($urandom);
        rf_q1 = 4'($urandom_range(0, 7));
        rf_q2 = 4'($urandom_range(0, 7));
        rf_v1 = $urandom; rf_v2 = $urandom;
        rob_q1_rdy = $urandom_range(0, 99) < 30;
        rob_q2_rdy = $urandom_range(0, 99) < 30;
        rob_v1 = $urandom; rob_v2 = $urandom;
        cdb_valid = 2'($urandom);
        cdb_tag = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
        cdb_data = {$urandom, $urandom};
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        check_regs();
        rst = 0;

        // Fill with the RS blocked, then drain in FIFO order.
        rs_full = 1;
        in_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            rand_instr();
            in_is_ls = 0;
            in_pc = 32'h100 + 32'(i * 4);
            tick();
        end
        chk("full_count", count, 8);
        chk("full_ready", in_ready, 0);
        in_valid = 0;
        rs_full = 0;
        for (int i = 0; i < DEPTH; i++) begin
            rob_id = 4'(i + 1);
            tick();
            chk("drain_pc", iss_pc, 32'h100 + 32'(i * 4));
        end

        // Back-to-back dependency on a freshly renamed register.
        idle_inputs();
        in_valid = 1; in_rd = 5; in_rs1 = 0; in_rs2 = 0;
        tick();
        in_rd = 6; in_rs1 = 5; in_rs2 = 5; rob_id = 3;
        tick();
        chk("dep_ren_tag", ren_tag, 3);
        in_valid = 0; rob_id = 4;
        tick();
        chk("dep_q1", iss_q1, 3);
        chk("dep_q2", iss_q2, 3);

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            tick();
        end

        // Flush, refill to five, issue one, then async reset mid-cycle.
        idle_inputs();
        rollback = 1; in_valid = 1;
        tick();
        chk("rb_count", count, 0);
        rollback = 0; rs_full = 1;
        for (int i = 0; i < 5; i++) begin
            rand_instr();
            in_is_ls = 0;
            tick();
        end
        in_valid = 0; rs_full = 0; rob_id = 9;
        tick();
        chk("pre_rst_count", count, 4);
        chk("pre_rst_rs_we", rs_we, 1);
        #2 rst = 1;
        #1;
        model_reset();
        chk("arst_count", count, 0);
        chk("arst_rs_we", rs_we, 0);
        chk("arst_rob_we", rob_we, 0);
        chk("arst_ren_we", ren_we, 0);
        @(negedge clk);
        rst = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- Parametrised successor to the single-slot dispatcher. It sits between the fetcher/decoder and the ROB, RS, LSB and register-file rename port.
- It buffers up to DEPTH decoded instructions and issues at most one per cycle when the ROB and the selected target station both have room.
- It resolves operands from the register file, the ROB and NUM_CDB result buses. It forwards the previous cycle's rename, so back-to-back dependent instructions issue with the correct tag.

Parameters:
- DEPTH, 8, queue entries; power of two, ≥2.
- NUM_CDB, 2, number of common-data-bus result channels.
- ROB_ID_W, 4, ROB tag width; tag 0 means "no dependency".
- XLEN, 32, data and pc width.
- OP_W, 6, optype width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rdy  in  1  global enable; low means pause.
- rollback  in  1  flush request.
- in_valid  in  1  decoded instruction offered.
- in_ready  out  1  queue can accept; equals (count<DEPTH) && !rollback.
- in_pc, in_imm  in  XLEN  pc and immediate.
- in_optype  in  OP_W  optype.
- in_rd, in_rs1, in_rs2  in  5  register indices.
- in_is_ls, in_is_jump, in_pred_jump  in  1  routing and prediction flags.
- rob_full, rs_full, lsb_full  in  1  per-target backpressure.
- rob_id  in  ROB_ID_W  tag the ROB will assign to the next instruction.
- rs1_idx, rs2_idx  out  5  head operand indices to the register file (combinational).
- rf_q1, rf_q2  in  ROB_ID_W  register-file rename tags.
- rf_v1, rf_v2  in  XLEN  register-file values.
- rob_q1_rdy, rob_q2_rdy  in  1  ROB reports the tag's result is ready.
- rob_v1, rob_v2  in  XLEN  ROB values.
- cdb_valid  in  NUM_CDB  per-channel result valid.
- cdb_tag  in  NUM_CDB*ROB_ID_W  flattened result tags.
- cdb_data  in  NUM_CDB*XLEN  flattened result data.
- rob_we  out  1  one-cycle ROB insert pulse.
- rob_pc  out  XLEN  insert pc.
- rob_rd  out  5  insert destination register.
- rob_optype  out  OP_W  insert optype.
- rob_is_jump, rob_pred_jump  out  1  insert jump flags.
- ren_we  out  1  register-file rename pulse.
- ren_rd  out  5  register being renamed.
- ren_tag  out  ROB_ID_W  new tag for that register.
- rs_we, lsb_we  out  1  issue pulse to RS or LSB.
- iss_tag  out  ROB_ID_W  tag of the issued instruction.
- iss_optype  out  OP_W  issued optype.
- iss_pc, iss_imm  out  XLEN  issued pc and immediate.
- iss_q1, iss_q2  out  ROB_ID_W  resolved operand tags.
- iss_v1, iss_v2  out  XLEN  resolved operand values.
- count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async): queue empty, head and tail pointers 0, count 0, every output register 0, all pulses low, the pending-rename register invalid.
- Enqueue: when in_valid && in_ready && rdy, write at tail, tail+1 mod DEPTH. An enqueue and an issue in the same cycle leave count unchanged.
- Full/empty: in_ready is low when full. The head is only examined when count>0.
- Issue condition: rdy && !rollback && count>0 && !rob_full && !(head.is_ls ? lsb_full : rs_full).
- Issue latency: all issue outputs are registered. An instruction enqueued at edge N can issue at edge N+1 at the earliest; its pulses are high during the following cycle.
- Issue actions:
  - rob_we=1.
  - rs_we = !is_ls; lsb_we = is_ls.
  - ren_we = (rd≠0); ren_rd = rd; ren_tag = rob_id.
  - Pulses drop to 0 on any cycle without an issue, except when rdy is low (see pause).
- Operand resolution, per source s, evaluated in priority order:
  1. rs_idx==0 → Q=0, V=0.
  2. Pending-rename hit: the previous cycle issued with ren_we and its ren_rd == rs_idx → Q = that ren_tag, V=0. Rules 3–4 are not applied; only rule 5 can still clear this Q.
  3. rob_qs_rdy → Q=0, V=rob_vs.
  4. Otherwise Q=rf_qs, V=rf_vs.
  5. Afterwards, if Q≠0 and some channel k has cdb_valid[k] && cdb_tag[k]==Q → Q=0, V=cdb_data[k]. The lowest k wins.
- Pause (rdy low): no enqueue, no issue, all output registers hold their values, including pulses. The pending-rename register also holds.
- Rollback (takes priority over everything except rst):
  - At the edge: count=0, pointers 0, all pulses 0, pending rename invalid.
  - That cycle: the enqueue is dropped and no issue occurs.
- Pointer wrap: head and tail wrap modulo DEPTH. count distinguishes full from empty.

Test Plan:
- Fill and drain: reset; push 8 non-ls ALU ops, never pushing while in_ready is low, with rs_full=1 → count=8, in_ready=0. Release rs_full → one rs_we per cycle for 8 cycles in FIFO pc order; count returns to 0.
- Routing and backpressure: head is a load with lsb_full=1 → no pulse, head holds. Drop lsb_full → lsb_we=1, rs_we=0, iss_tag=rob_id. With rob_full=1 nothing issues regardless of the station full signals.
- Back-to-back dependency: issue "addi x5" with rob_id=3, then "add x6,x5,x5" the next cycle while rf_q1=0 (stale) → iss_q1=3, iss_q2=3. If in that cycle cdb_valid[1]=1, cdb_tag=3, cdb_data=0x2A → q=0, v=0x2A.
- CDB priority and x0: both channels hit tag 7 with data 0x11 (ch0) and 0x22 (ch1) → v=0x11. A source of x0 with rf_q=5 → q=0, v=0; rd=x0 → ren_we=0.
- Rollback and pause: with 5 queued entries, assert rollback concurrently with in_valid → next cycle count=0 and no pulses. With rdy=0 during an issue pulse, the pulse and its payload hold unchanged until rdy=1.
- Async reset mid-operation: assert rst between edges with count=4 → count=0 and all pulses 0 immediately, without waiting for a clock edge.
